// File: rtl/mem_stage.sv
// Memory-access stage: registers one instruction from execute, runs a byte/half/word
// load or store over a req/ready handshake, and hands one extended result to write-back.
module mem_lane #(
  parameter int LANE = 0
) (
  input  logic [1:0]  size,
  input  logic [1:0]  lo,
  input  logic [31:0] wd,
  output logic        be,
  output logic [7:0]  wbyte
);
  always_comb begin
    be    = 1'b0;
    wbyte = wd[7:0];
    case (size)
      2'b00: be = (lo == 2'(LANE));
      2'b01: begin
        be    = (lo[1] == LANE[1]);
        wbyte = LANE[0] ? wd[15:8] : wd[7:0];
      end
      2'b10: begin
        be    = 1'b1;
        wbyte = wd[8*LANE +: 8];
      end
      default: ;
    endcase
  end
endmodule

module mem_stage #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        valid_in,
  input  logic [31:0] addr,
  input  logic [31:0] write_data,
  input  logic [31:0] Rin,
  input  logic        mem_rd,
  input  logic        mem_wr,
  input  logic [1:0]  mem_size,
  input  logic        mem_unsigned,
  input  logic [4:0]  rd,
  input  logic        reg_wr,
  output logic        busy,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic        dmem_ready,
  input  logic [31:0] dmem_rdata,
  output logic        valid_out,
  output logic [31:0] wb_data,
  output logic [4:0]  wb_rd,
  output logic        wb_we,
  output logic        misalign,
  output logic        bus_err
);
  localparam int NUM_LANES = 4;
  localparam int CW        = $clog2(TIMEOUT + 1);

  typedef enum logic {IDLE, WAIT} state_t;

  // Fields of the outstanding access needed at completion time.
  typedef struct packed {
    logic       load;
    logic [1:0] size;
    logic       uns;
    logic [1:0] lo;
    logic [4:0] rd;
    logic       reg_wr;
  } op_t;

  state_t        state, state_nx;
  logic [CW-1:0] cnt;
  op_t           op;
  logic          accept, is_mem, mis, done, abort;
  logic [NUM_LANES-1:0]      be_nx;
  logic [NUM_LANES-1:0][7:0] wdata_nx;
  logic [31:0]   lane_v, load_val;

  assign busy     = (state == WAIT);
  // Combinational from state so an async reset drops the request immediately.
  assign dmem_req = (state == WAIT);
  assign accept   = valid_in && (state == IDLE);
  assign is_mem   = mem_rd || mem_wr;
  assign mis      = (mem_size == 2'b11) ||
                    (mem_size == 2'b01 && addr[0]) ||
                    (mem_size == 2'b10 && addr[1:0] != 2'b00);

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    mem_lane #(.LANE(i)) u_lane (
      .size  (mem_size),
      .lo    (addr[1:0]),
      .wd    (write_data),
      .be    (be_nx[i]),
      .wbyte (wdata_nx[i])
    );
  end

  always_comb begin
    lane_v   = dmem_rdata >> {op.lo, 3'b000};
    load_val = lane_v;
    case (op.size)
      2'b00:   load_val = {{24{~op.uns & lane_v[7]}},  lane_v[7:0]};
      2'b01:   load_val = {{16{~op.uns & lane_v[15]}}, lane_v[15:0]};
      default: load_val = lane_v;
    endcase
  end

  always_comb begin
    state_nx = state;
    done     = 1'b0;
    abort    = 1'b0;
    case (state)
      IDLE: if (accept && is_mem && !mis) state_nx = WAIT;
      WAIT: begin
        // Ready on the final allowed cycle still completes normally.
        if (dmem_ready) begin
          done     = 1'b1;
          state_nx = IDLE;
        end else if (cnt == CW'(TIMEOUT - 1)) begin
          abort    = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE)    cnt <= '0;
      else if (!dmem_ready) cnt <= cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op         <= '0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
      dmem_be    <= '0;
      valid_out  <= 1'b0;
      wb_data    <= '0;
      wb_rd      <= '0;
      wb_we      <= 1'b0;
      misalign   <= 1'b0;
      bus_err    <= 1'b0;
    end else begin
      valid_out <= 1'b0;
      misalign  <= 1'b0;
      bus_err   <= 1'b0;
      if (accept) begin
        op <= '{load: mem_rd & ~mem_wr, size: mem_size, uns: mem_unsigned,
                lo: addr[1:0], rd: rd, reg_wr: reg_wr};
        if (!is_mem) begin
          valid_out <= 1'b1;
          wb_data   <= Rin;
          wb_rd     <= rd;
          wb_we     <= reg_wr;
        end else if (mis) begin
          valid_out <= 1'b1;
          misalign  <= 1'b1;
          wb_data   <= '0;
          wb_rd     <= rd;
          wb_we     <= 1'b0;
        end else begin
          dmem_we    <= mem_wr;
          dmem_addr  <= {addr[31:2], 2'b00};
          dmem_wdata <= wdata_nx;
          dmem_be    <= be_nx;
        end
      end
      if (done) begin
        valid_out <= 1'b1;
        wb_data   <= op.load ? load_val : 32'h0;
        wb_rd     <= op.rd;
        wb_we     <= op.load & op.reg_wr;
      end
      if (abort) begin
        valid_out <= 1'b1;
        bus_err   <= 1'b1;
        wb_data   <= '0;
        wb_rd     <= op.rd;
        wb_we     <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: stimulus pushes expected write-back records into a
// queue, an independent monitor pops and compares on every valid_out pulse.
module tb_mem_stage;
  logic        clk = 0, rst_n = 0;
  logic        valid_in = 0;
  logic [31:0] addr = 0, write_data = 0, Rin = 0;
  logic        mem_rd = 0, mem_wr = 0;
  logic [1:0]  mem_size = 0;
  logic        mem_unsigned = 0;
  logic [4:0]  rd = 0;
  logic        reg_wr = 0;
  logic        busy, dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_ready = 0;
  logic [31:0] dmem_rdata = 0;
  logic        valid_out;
  logic [31:0] wb_data;
  logic [4:0]  wb_rd;
  logic        wb_we, misalign, bus_err;

  int checks = 0, errors = 0;

  typedef struct {
    logic [31:0] data;
    logic [4:0]  rd;
    logic        we, mis, berr;
  } exp_t;
  exp_t exp_q[$];

  mem_stage #(.TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .addr(addr),
    .write_data(write_data), .Rin(Rin), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_size(mem_size), .mem_unsigned(mem_unsigned), .rd(rd), .reg_wr(reg_wr),
    .busy(busy), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_ready(dmem_ready),
    .dmem_rdata(dmem_rdata), .valid_out(valid_out), .wb_data(wb_data),
    .wb_rd(wb_rd), .wb_we(wb_we), .misalign(misalign), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, got, exp);
    end
  endtask

  task automatic expect_wb(input logic [31:0] d, input logic [4:0] r,
                           input logic we, input logic m, input logic be);
    exp_t e;
    e.data = d; e.rd = r; e.we = we; e.mis = m; e.berr = be;
    exp_q.push_back(e);
  endtask

  // Presents one instruction and returns just after the acceptance edge (cycle 0).
  task automatic send(input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rin,
                      input logic [4:0] r, input logic mrd, input logic mwr,
                      input logic [1:0] sz, input logic u, input logic rw);
    @(negedge clk);
    addr = a; write_data = wd; Rin = rin; rd = r; mem_rd = mrd; mem_wr = mwr;
    mem_size = sz; mem_unsigned = u; reg_wr = rw; valid_in = 1;
    @(posedge clk);
    #1 valid_in = 0;
  endtask

  task automatic check_req(input string name, input logic we, input logic [31:0] a,
                           input logic [3:0] be, input logic [31:0] wd);
    @(negedge clk);
    chk({name, "_req"},  {31'b0, dmem_req}, 1);
    chk({name, "_busy"}, {31'b0, busy}, 1);
    chk({name, "_we"},   {31'b0, dmem_we}, {31'b0, we});
    chk({name, "_addr"}, dmem_addr, a);
    chk({name, "_be"},   {28'b0, dmem_be}, {28'b0, be});
    if (we) chk({name, "_wdata"}, dmem_wdata, wd);
  endtask

  // Called in cycle 1; holds ready low nlow more cycles, then pulses it for one.
  // With junk set, a non-memory instruction is offered while busy and must be ignored.
  task automatic respond(input int nlow, input logic [31:0] rdata, input logic junk,
                         input logic [31:0] a);
    if (junk) begin
      mem_rd = 0; mem_wr = 0; Rin = 32'hBAD0_BAD0; valid_in = 1;
    end
    for (int i = 0; i < nlow; i++) begin
      @(negedge clk);
      chk("busy_wait", {31'b0, busy}, 1);
      chk("addr_stable", dmem_addr, a);
    end
    valid_in = 0;
    dmem_ready = 1; dmem_rdata = rdata;
    @(posedge clk);
    #1 dmem_ready = 0; dmem_rdata = 32'h0;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (valid_out) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_valid wb_data %h wb_rd %0d", wb_data, wb_rd);
      end else begin
        e = exp_q.pop_front();
        chk("wb_data",  wb_data, e.data);
        chk("wb_rd",    {27'b0, wb_rd}, {27'b0, e.rd});
        chk("wb_we",    {31'b0, wb_we}, {31'b0, e.we});
        chk("misalign", {31'b0, misalign}, {31'b0, e.mis});
        chk("bus_err",  {31'b0, bus_err}, {31'b0, e.berr});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    #3;
    chk("rst_ctrl", {20'b0, busy, dmem_req, dmem_we, dmem_be, valid_out, wb_we, misalign, bus_err, wb_rd}, 0);
    chk("rst_addr", dmem_addr, 0);
    chk("rst_wdata", dmem_wdata, 0);
    chk("rst_wb_data", wb_data, 0);
    #20 rst_n = 1;

    // non-memory
    expect_wb(32'h1234_5678, 7, 1, 0, 0);
    send(32'h0, 32'h0, 32'h1234_5678, 7, 0, 0, 2'b10, 0, 1);
    @(negedge clk);
    chk("nm_valid", {31'b0, valid_out}, 1);
    chk("nm_req", {31'b0, dmem_req}, 0);
    @(negedge clk);
    chk("nm_pulse", {31'b0, valid_out}, 0);
    chk("nm_hold", wb_data, 32'h1234_5678);

    // signed byte load
    expect_wb(32'hFFFF_FF80, 3, 1, 0, 0);
    send(32'h103, 32'h0, 32'h0, 3, 1, 0, 2'b00, 0, 1);
    check_req("lb", 0, 32'h100, 4'b1000, 0);
    respond(0, 32'h80FF_0000, 0, 32'h100);
    @(negedge clk);
    chk("lb_valid_c2", {31'b0, valid_out}, 1);
    chk("lb_req_off", {31'b0, dmem_req}, 0);

    // unsigned byte load
    expect_wb(32'h0000_0080, 3, 1, 0, 0);
    send(32'h103, 32'h0, 32'h0, 3, 1, 0, 2'b00, 1, 1);
    check_req("lbu", 0, 32'h100, 4'b1000, 0);
    respond(0, 32'h80FF_0000, 0, 32'h100);

    // half store
    expect_wb(32'h0, 9, 0, 0, 0);
    send(32'h22, 32'h0000_ABCD, 32'h0, 9, 0, 1, 2'b01, 0, 1);
    check_req("sh", 1, 32'h20, 4'b1100, 32'hABCD_ABCD);
    respond(0, 32'h0, 0, 32'h20);

    // word load, ready low 3 cycles, upstream offered junk while busy
    expect_wb(32'hDEAD_BEEF, 5, 1, 0, 0);
    send(32'h40, 32'h0, 32'h0, 5, 1, 0, 2'b10, 0, 1);
    check_req("lw", 0, 32'h40, 4'b1111, 0);
    respond(3, 32'hDEAD_BEEF, 1, 32'h40);
    @(negedge clk);
    chk("lw_valid_c5", {31'b0, valid_out}, 1);
    chk("lw_busy_off", {31'b0, busy}, 0);

    // signed half load at upper half, ready on last allowed cycle
    expect_wb(32'hFFFF_8001, 2, 1, 0, 0);
    send(32'h12, 32'h0, 32'h0, 2, 1, 0, 2'b01, 0, 1);
    check_req("lh", 0, 32'h10, 4'b1100, 0);
    respond(3, 32'h8001_0000, 0, 32'h10);

    // misaligned word
    expect_wb(32'h0, 4, 0, 1, 0);
    send(32'h02, 32'h0, 32'h0, 4, 1, 0, 2'b10, 0, 1);
    @(negedge clk);
    chk("mis_valid", {31'b0, valid_out}, 1);
    chk("mis_req", {31'b0, dmem_req}, 0);

    // timeout
    expect_wb(32'h0, 6, 0, 0, 1);
    send(32'h80, 32'h0, 32'h0, 6, 1, 0, 2'b10, 0, 1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("to_busy", {31'b0, busy}, 1);
    end
    @(negedge clk);
    chk("to_valid_c5", {31'b0, valid_out}, 1);
    chk("to_req_off", {31'b0, dmem_req}, 0);

    // reset in the second WAIT cycle, then a fresh load
    send(32'h200, 32'h0, 32'h0, 8, 1, 0, 2'b10, 0, 1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 0;
    #1;
    chk("rst_req_drop", {31'b0, dmem_req}, 0);
    chk("rst_busy_drop", {31'b0, busy}, 0);
    @(negedge clk);
    rst_n = 1;
    expect_wb(32'h1122_3344, 10, 1, 0, 0);
    send(32'h204, 32'h0, 32'h0, 10, 1, 0, 2'b10, 0, 1);
    check_req("post_rst", 0, 32'h204, 4'b1111, 0);
    respond(0, 32'h1122_3344, 0, 32'h204);

    // back-to-back non-memory
    expect_wb(32'hAAAA_0001, 11, 1, 0, 0);
    expect_wb(32'hBBBB_0002, 12, 0, 0, 0);
    @(negedge clk);
    mem_rd = 0; mem_wr = 0; Rin = 32'hAAAA_0001; rd = 11; reg_wr = 1; valid_in = 1;
    @(posedge clk);
    #1 Rin = 32'hBBBB_0002; rd = 12; reg_wr = 0;
    @(negedge clk);
    chk("b2b_v1", {31'b0, valid_out}, 1);
    @(posedge clk);
    #1 valid_in = 0;
    @(negedge clk);
    chk("b2b_v2", {31'b0, valid_out}, 1);

    repeat (4) @(negedge clk);
    chk("queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
